// File: rtl/ps2_seq_pkg.sv
// rtl/ps2_seq_pkg.sv - shared types and scan-code constants for the PS/2 scan sequencer
package ps2_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GOT_E0 = 2'd1,
        ST_GOT_F0 = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PS2_ERR_00     = 8'h00;
    localparam logic [7:0] PS2_ERR_FF     = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Receiver error bytes carry no key information and abort any prefix
    function automatic logic is_err_code(input logic [7:0] b);
        return (b == PS2_ERR_00) || (b == PS2_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word-fall-through event FIFO with count and drop flag
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_hold;
    logic          w_pop;
    logic          w_wr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr    = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & o_full & ~w_pop;
    assign o_valid = ~o_empty;
    assign o_count = r_count;
    // When empty, present the last head so the outputs stay stable
    assign o_data  = o_empty ? r_hold : r_mem[r_rd_ptr];

    // Storage write, pointer advance and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (!o_empty) r_hold <= r_mem[r_rd_ptr];
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// rtl/ps2_scan_sequencer.sv - PS/2 byte strobe, prefix decode FSM and key event queue; optional PS2_TYPEMATIC_FILTER_EN
module ps2_scan_sequencer
    import ps2_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bsy,
    input  logic [CODE_W-1:0]          data_in,
    input  logic                       ev_ready,
    output logic                       ev_valid,
    output logic [CODE_W-1:0]          ev_code,
    output logic                       ev_break,
    output logic                       ev_ext,
    output logic [$clog2(DEPTH+1)-1:0] ev_count,
    output logic                       overflow
);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_GOT_E0  = ST_GOT_E0;
    localparam logic [1:0] S_GOT_F0  = ST_GOT_F0;
    localparam logic [1:0] S_GOT_E0F0 = ST_GOT_E0F0;

    logic       r_bsy_q;
    logic       r_strobe_q;
    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_overflow;
    logic       w_emit;
    logic       w_ext;
    logic       w_brk;
    logic       w_filtered;
    logic       w_push;
    logic       w_drop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_byte;
    logic       w_is_e0;
    logic       w_is_f0;
    logic       w_is_err;
    ps2_event_t w_new_ev;
    ps2_event_t w_head;

    assign w_byte   = 8'(data_in);
    assign w_is_e0  = (w_byte == PS2_PREFIX_EXT);
    assign w_is_f0  = (w_byte == PS2_PREFIX_BRK);
    assign w_is_err = is_err_code(w_byte);

    // Falling edge of bsy marks a completed byte one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bsy_q    <= 1'b0;
            r_strobe_q <= 1'b0;
        end else begin
            r_bsy_q    <= bsy;
            r_strobe_q <= r_bsy_q & ~bsy;
        end
    end

    // Prefix decode: prefixes steer state, error bytes abort, plain codes emit
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_ext        = 1'b0;
        w_brk        = 1'b0;
        if (r_strobe_q) begin
            if (w_is_err) begin
                w_next_state = S_IDLE;
            end else if (w_is_e0) begin
                w_next_state = S_GOT_E0;
            end else if (w_is_f0) begin
                w_next_state = (r_state == S_GOT_E0) ? S_GOT_E0F0 : S_GOT_F0;
            end else begin
                w_emit       = 1'b1;
                w_ext        = (r_state == S_GOT_E0) || (r_state == S_GOT_E0F0);
                w_brk        = (r_state == S_GOT_F0) || (r_state == S_GOT_E0F0);
                w_next_state = S_IDLE;
            end
        end
    end

    // Decoder state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       r_lm_valid;
    logic       r_lm_ext;
    logic [7:0] r_lm_code;
    logic       w_lm_match;

    assign w_lm_match = r_lm_valid && (r_lm_ext == w_ext) && (r_lm_code == w_byte);
    assign w_filtered = w_emit & ~w_brk & w_lm_match;

    // Remember the last make so auto-repeat copies are suppressed until release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lm_valid <= 1'b0;
            r_lm_ext   <= 1'b0;
            r_lm_code  <= '0;
        end else if (w_emit && !w_filtered) begin
            if (!w_brk) begin
                r_lm_valid <= 1'b1;
                r_lm_ext   <= w_ext;
                r_lm_code  <= w_byte;
            end else if (w_lm_match) begin
                r_lm_valid <= 1'b0;
            end
        end
    end
`else
    assign w_filtered = 1'b0;
`endif

    assign w_push   = w_emit & ~w_filtered;
    assign w_new_ev = '{ext: w_ext, brk: w_brk, code: w_byte};

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(ps2_event_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (w_new_ev),
        .i_pop   (ev_ready),
        .o_data  (w_head),
        .o_valid (ev_valid),
        .o_count (ev_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // Sticky record that an event was lost to a full queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;
    assign ev_code  = CODE_W'(w_head.code);
    assign ev_break = w_head.brk;
    assign ev_ext   = w_head.ext;

endmodule
